cfg_commit_ctrl: RTL
====================

CFG_COMMIT_CTRL -- requirements
Module: cfg_commit_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000 (range 2..65535): maximum clk cycles to wait in ARMED for frame_sync.
REQ-002 SHALL have parameter RST_CFG, default 64'h0: reset value of the shadow and active register banks.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_stb  input  1  single-cycle byte-write strobe from the SPI command decoder.
REQ-006 wr_addr  input  3  shadow register index 0..7.
REQ-007 wr_data  input  8  byte to write.
REQ-008 commit_req  input  1  single-cycle request to apply the shadow bank to the active bank.
REQ-009 frame_sync  input  1  datapath frame-boundary pulse; the only cycle on which the active bank may change.
REQ-010 abort  input  1  cancels a pending commit.
REQ-011 active_cfg  output  64  active bank; byte n is bits [8n+7:8n].
REQ-012 dirty  output  8  per-register flag: shadow written since the last apply.
REQ-013 busy  output  1  high in ARMED or APPLY.
REQ-014 commit_ack  output  1  one-cycle pulse after a successful apply.
REQ-015 wr_err  output  1  one-cycle pulse when a write is rejected.
REQ-016 timeout_err  output  1  sticky commit-timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, ARMED, APPLY and DONE, and SHALL be in IDLE after reset.
REQ-018 In IDLE, wr_stb SHALL write wr_data to shadow[wr_addr] and set dirty[wr_addr] on the next edge.
- A second write to the same address before apply SHALL overwrite the first; last write wins.
REQ-019 In IDLE, commit_req SHALL move the FSM to ARMED, clear timeout_err, and load the wait counter with 0.
- If commit_req and wr_stb arrive in the same cycle, the write SHALL be accepted first and included in the commit.
REQ-020 In ARMED, the wait counter SHALL increment each cycle.
- frame_sync SHALL move the FSM to APPLY.
- abort SHALL move the FSM to IDLE, keeping shadow and dirty.
- If frame_sync and abort are both high in the same cycle, abort SHALL win.
REQ-021 APPLY SHALL last exactly one cycle.
- active_cfg SHALL be updated on its closing edge, but only for bytes whose dirty bit is set.
- All dirty bits SHALL clear on that same edge.
- The FSM SHALL then move to DONE.
REQ-022 DONE SHALL last one cycle, assert commit_ack, and return to IDLE.
- Latency from frame_sync sampled high in ARMED to commit_ack high SHALL be 2 cycles.
REQ-023 A commit with dirty==0 SHALL still run the full sequence and assert commit_ack; active_cfg SHALL not change.
REQ-024 wr_stb in ARMED, APPLY or DONE SHALL be dropped and SHALL pulse wr_err on the next cycle; shadow and dirty SHALL be unchanged.
REQ-025 commit_req outside IDLE SHALL be ignored, with no error flag.
REQ-026 frame_sync outside ARMED SHALL have no effect.
REQ-027 busy SHALL be a registered decode of the state: high in ARMED and APPLY, low in IDLE and DONE.
REQ-028 active_cfg SHALL never change on any cycle other than the closing edge of APPLY.

Reset
REQ-029 While rst_n is low, regardless of state, the block SHALL set:
- shadow and active_cfg to RST_CFG;
- dirty to 0;
- busy, commit_ack, wr_err and timeout_err to 0;
- the wait counter to 0;
- the FSM to IDLE.
- A commit pending at reset SHALL be discarded without commit_ack.
REQ-030 The first edge after rst_n deasserts SHALL accept wr_stb normally.

Configuration
REQ-031 Macro CFG_COMMIT_TIMEOUT_EN, when defined, SHALL enable the timeout.
- When the ARMED wait counter reaches TIMEOUT_CYC-1 without frame_sync, the FSM SHALL go to IDLE and set timeout_err on the same edge.
- shadow and dirty SHALL be kept so that a later commit_req retries the same values.
- If frame_sync arrives on the terminal-count cycle, frame_sync SHALL win.
REQ-032 When CFG_COMMIT_TIMEOUT_EN is not defined:
- ARMED SHALL wait indefinitely, and the wait counter SHALL be omitted.
- timeout_err SHALL be constant 0.
- The port list SHALL be unchanged.

Verification
REQ-033 Write sequence:
- Stimulus: write addr2=0x5A, then addr2=0xA5, then commit_req, then frame_sync 5 cycles later.
- Response: dirty=0x04 before apply; active_cfg[23:16]=0xA5 and all other bytes unchanged; commit_ack 2 cycles after frame_sync; dirty=0x00.
REQ-034 Rejected write:
- Stimulus: in ARMED, wr_stb with addr0=0xFF.
- Response: wr_err pulses once; shadow[0] and dirty unchanged; following commit leaves active_cfg[7:0] at its old value.
REQ-035 Abort versus frame_sync:
- Stimulus: frame_sync and abort high in the same ARMED cycle.
- Response: FSM returns to IDLE; no commit_ack; active_cfg unchanged; dirty retained.
REQ-036 Timeout (only with CFG_COMMIT_TIMEOUT_EN, TIMEOUT_CYC=8):
- Stimulus: commit_req with no frame_sync.
- Response: timeout_err=1 and busy=0 after 8 cycles in ARMED; a second commit_req clears timeout_err; frame_sync then completes the commit.
REQ-037 Reset mid-commit:
- Stimulus: rst_n pulsed low while in APPLY.
- Response: all outputs at reset values; active_cfg=RST_CFG; no commit_ack.
REQ-038 Empty commit:
- Stimulus: commit_req with dirty=0, then frame_sync.
- Response: commit_ack pulses; active_cfg unchanged.

Source files
------------

// File: rtl/cfg_commit_ctrl_if.sv
// Configuration-commit bus: SPI byte writes and commit control in, active bank and status out.
interface cfg_commit_ctrl_if;
  logic        wr_stb;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        commit_req;
  logic        frame_sync;
  logic        abort;
  logic [63:0] active_cfg;
  logic [7:0]  dirty;
  logic        busy;
  logic        commit_ack;
  logic        wr_err;
  logic        timeout_err;

  modport master (
    output wr_stb, wr_addr, wr_data, commit_req, frame_sync, abort,
    input  active_cfg, dirty, busy, commit_ack, wr_err, timeout_err
  );

  modport slave (
    input  wr_stb, wr_addr, wr_data, commit_req, frame_sync, abort,
    output active_cfg, dirty, busy, commit_ack, wr_err, timeout_err
  );
endinterface

// File: rtl/cfg_commit_ctrl.sv
// Shadow/active configuration bank with frame-synchronous commit.
// Define CFG_COMMIT_TIMEOUT_EN to bound the ARMED wait by TIMEOUT_CYC cycles.
module cfg_commit_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter logic [63:0] RST_CFG     = 64'h0
) (
  input logic                    clk,
  input logic                    rst_n,
  cfg_commit_ctrl_if.slave       io_bus
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_param_check
    $error("TIMEOUT_CYC must be in 2..65535");
  end

  typedef enum logic [1:0] {StIdle, StArmed, StApply, StDone} state_e;

  state_e          r_state, w_state_nxt;
  logic [7:0][7:0] r_shadow, w_shadow_nxt;
  logic [7:0][7:0] r_active, w_active_nxt;
  logic [7:0]      r_dirty, w_dirty_nxt;
  logic            r_busy, r_ack, r_wr_err;
  logic            w_busy_nxt, w_ack_nxt, w_wr_err_nxt;

`ifdef CFG_COMMIT_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] r_wait_cnt, w_wait_cnt_nxt;
  logic        r_timeout_err, w_timeout_err_nxt;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_active_nxt = r_active;
    w_dirty_nxt  = r_dirty;
    // Writes are only legal in IDLE; anything else is flagged one cycle later.
    w_wr_err_nxt = io_bus.wr_stb && (r_state != StIdle);
`ifdef CFG_COMMIT_TIMEOUT_EN
    w_wait_cnt_nxt    = r_wait_cnt;
    w_timeout_err_nxt = r_timeout_err;
`endif

    unique case (r_state)
      StIdle: begin
        if (io_bus.wr_stb) begin
          w_shadow_nxt[io_bus.wr_addr] = io_bus.wr_data;
          w_dirty_nxt[io_bus.wr_addr]  = 1'b1;
        end
        if (io_bus.commit_req) begin
          w_state_nxt = StArmed;
`ifdef CFG_COMMIT_TIMEOUT_EN
          w_wait_cnt_nxt    = 16'd0;
          w_timeout_err_nxt = 1'b0;
`endif
        end
      end
      StArmed: begin
`ifdef CFG_COMMIT_TIMEOUT_EN
        w_wait_cnt_nxt = r_wait_cnt + 16'd1;
`endif
        if (io_bus.abort) begin
          w_state_nxt = StIdle;
        end else if (io_bus.frame_sync) begin
          w_state_nxt = StApply;
`ifdef CFG_COMMIT_TIMEOUT_EN
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt       = StIdle;
          w_timeout_err_nxt = 1'b1;
`endif
        end
      end
      StApply: begin
        for (int n = 0; n < 8; n++) begin
          if (r_dirty[n]) begin
            w_active_nxt[n] = r_shadow[n];
          end
        end
        w_dirty_nxt = '0;
        w_state_nxt = StDone;
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase

    // Status outputs are registered decodes of the next state.
    w_busy_nxt = (w_state_nxt == StArmed) || (w_state_nxt == StApply);
    w_ack_nxt  = (w_state_nxt == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_shadow <= RST_CFG;
      r_active <= RST_CFG;
      r_dirty  <= '0;
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_active <= w_active_nxt;
      r_dirty  <= w_dirty_nxt;
      r_busy   <= w_busy_nxt;
      r_ack    <= w_ack_nxt;
      r_wr_err <= w_wr_err_nxt;
    end
  end

`ifdef CFG_COMMIT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt    <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign io_bus.timeout_err = r_timeout_err;
`else
  assign io_bus.timeout_err = 1'b0;
`endif

  assign io_bus.active_cfg = r_active;
  assign io_bus.dirty      = r_dirty;
  assign io_bus.busy       = r_busy;
  assign io_bus.commit_ack = r_ack;
  assign io_bus.wr_err     = r_wr_err;

endmodule
